// File: rtl/cipher_cfg_loader.sv
`default_nettype none
// ============================================================================
// cipher_cfg_loader: streams a parallel config word LSB-first into the cipher
// cfg scan chain while capturing the outgoing chain contents for readback.
// Revision: 1.0
// ============================================================================
module cipher_cfg_loader #(
  parameter int CFG_W = 67,
  parameter int CNT_W = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [CFG_W-1:0] wr_data,
  output logic [CFG_W-1:0] rd_data,
  output logic             rd_valid,
  output logic             busy,
  output logic             cfg_en,
  output logic             cfg_i,
  input  logic             cfg_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CFG_W - 1);

  state_t           state;
  state_t           state_nxt;
  logic [CFG_W-1:0] tx_sr;
  logic [CFG_W-1:0] rx_sr;
  logic [CNT_W-1:0] cnt;
  logic             last_shift;

  always_comb begin
    state_nxt  = state;
    req_ready  = 1'b0;
    rd_valid   = 1'b0;
    busy       = 1'b0;
    last_shift = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_nxt = SHIFT;
      end
      SHIFT: begin
        busy = 1'b1;
        if (cnt == LAST_CNT) begin
          last_shift = 1'b1;
          state_nxt  = DONE;
        end
      end
      DONE: begin
        busy      = 1'b1;
        rd_valid  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // cfg_en is its own flop so the cipher sees a clean enable; cfg_i is gated by it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      tx_sr   <= '0;
      rx_sr   <= '0;
      cnt     <= '0;
      rd_data <= '0;
      cfg_en  <= 1'b0;
    end else begin
      state  <= state_nxt;
      cfg_en <= (state_nxt == SHIFT);
      case (state)
        IDLE: begin
          if (req_valid) begin
            tx_sr <= wr_data;
            cnt   <= '0;
          end
        end
        SHIFT: begin
          tx_sr <= {1'b0, tx_sr[CFG_W-1:1]};
          rx_sr <= {cfg_o, rx_sr[CFG_W-1:1]};
          cnt   <= cnt + CNT_W'(1);
          // Final chain bit arrives on this edge, so capture it directly.
          if (last_shift) rd_data <= {cfg_o, rx_sr[CFG_W-1:1]};
        end
        default: ;
      endcase
    end
  end

  assign cfg_i = cfg_en & tx_sr[0];

endmodule
`default_nettype wire

// File: tb/tb_cipher_cfg_loader.sv
`default_nettype none
// Directed bench for cipher_cfg_loader with a behavioural model of the
// cipher's 67-bit cfg scan chain attached.
module tb_cipher_cfg_loader;

  localparam int W = 67;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic [W-1:0] wr_data = '0;
  logic [W-1:0] rd_data;
  logic         rd_valid;
  logic         busy;
  logic         cfg_en;
  logic         cfg_i;
  logic         cfg_o;

  logic [W-1:0] chain;
  logic         pre_en = 1'b0;
  logic [W-1:0] pre_val = '0;

  int total = 0;
  int bad = 0;

  cipher_cfg_loader #(.CFG_W(W), .CNT_W(7)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .wr_data(wr_data), .rd_data(rd_data), .rd_valid(rd_valid), .busy(busy),
    .cfg_en(cfg_en), .cfg_i(cfg_i), .cfg_o(cfg_o)
  );

  always #5 clk = ~clk;

  // Cipher chain: bit 0 is visible on cfg_o, cfg_i enters at the top.
  always @(posedge clk) begin
    if (pre_en) chain <= pre_val;
    else if (cfg_en) chain <= {cfg_i, chain[W-1:1]};
  end
  assign cfg_o = chain[0];

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [W-1:0] v);
    pre_en = 1'b1;
    pre_val = v;
    step();
    pre_en = 1'b0;
  endtask

  // Present a word and return in cycle T+1, where T is the accepting edge.
  task automatic accept(input string tag, input logic [W-1:0] w);
    req_valid = 1'b1;
    wr_data = w;
    for (int i = 0; i < 200; i++) begin
      if (req_ready) break;
      step();
    end
    check({tag, "_ready"}, W'(req_ready), W'(1));
    step();
    req_valid = 1'b0;
    wr_data = ~w;
  endtask

  // Observe 80 cycles after acceptance (cycle index 1 = T+1).
  task automatic observe(input int inject_at, output int en_cnt, output int en_first,
                         output int en_last, output logic [W-1:0] seq,
                         output int rdv_first, output int rdv_cnt, output int rdy_first);
    en_cnt = 0; en_first = 0; en_last = 0; seq = '0;
    rdv_first = 0; rdv_cnt = 0; rdy_first = 0;
    for (int idx = 1; idx <= 80; idx++) begin
      if (cfg_en) begin
        if (en_cnt < W) seq[en_cnt] = cfg_i;
        en_cnt++;
        if (en_first == 0) en_first = idx;
        en_last = idx;
      end
      if (rd_valid) begin
        rdv_cnt++;
        if (rdv_first == 0) rdv_first = idx;
      end
      if (req_ready && rdy_first == 0) rdy_first = idx;
      if (idx == inject_at) begin
        req_valid = 1'b1;
        wr_data = W'(1);
      end
      step();
      if (idx == inject_at) req_valid = 1'b0;
    end
  endtask

  logic [W-1:0] seq;
  int en_cnt, en_first, en_last, rdv_first, rdv_cnt, rdy_first;
  int acc2, rdv_a, rdv_b, en_tot;
  logic acc_done;

  localparam logic [W-1:0] W2   = 67'h5_0000_0060_0000_0055;
  localparam logic [W-1:0] PRE3 = 67'h0_0000_0060_0000_0055;
  localparam logic [W-1:0] ONES = 67'h7_FFFF_FFFF_FFFF_FFFF;
  localparam logic [W-1:0] WB   = 67'h2_1234_5678_9ABC_DEF0;
  localparam logic [W-1:0] W6   = 67'h3_A5A5_0F0F_C3C3_1E1E;

  initial begin
    // Reset state
    #3;
    check("rst_cfg_en", W'(cfg_en), W'(0));
    check("rst_busy", W'(busy), W'(0));
    check("rst_rd_valid", W'(rd_valid), W'(0));
    check("rst_cfg_i", W'(cfg_i), W'(0));
    check("rst_rd_data", rd_data, '0);
    #14 rst = 1'b1;
    step();
    check("rst_req_ready", W'(req_ready), W'(1));
    preload('0);

    // Basic load
    accept("load", W2);
    observe(0, en_cnt, en_first, en_last, seq, rdv_first, rdv_cnt, rdy_first);
    check("load_en_cnt", W'(en_cnt), W'(67));
    check("load_en_first", W'(en_first), W'(1));
    check("load_en_last", W'(en_last), W'(67));
    check("load_cfg_i_seq", seq, W2);
    check("load_chain", chain, W2);
    check("load_rdv_at", W'(rdv_first), W'(68));
    check("load_rdv_cnt", W'(rdv_cnt), W'(1));
    check("load_ready_at", W'(rdy_first), W'(69));
    check("load_rd_data", rd_data, '0);

    // Readback of previous chain contents
    preload(PRE3);
    accept("rb1", ONES);
    observe(0, en_cnt, en_first, en_last, seq, rdv_first, rdv_cnt, rdy_first);
    check("rb1_rd_data", rd_data, PRE3);
    check("rb1_chain", chain, ONES);
    accept("rb2", '0);
    observe(0, en_cnt, en_first, en_last, seq, rdv_first, rdv_cnt, rdy_first);
    check("rb2_rd_data", rd_data, ONES);
    check("rb2_chain", chain, '0);

    // Request while busy is ignored
    accept("busy", W2);
    observe(10, en_cnt, en_first, en_last, seq, rdv_first, rdv_cnt, rdy_first);
    check("busy_en_cnt", W'(en_cnt), W'(67));
    check("busy_cfg_i_seq", seq, W2);
    check("busy_chain", chain, W2);
    check("busy_rdv_cnt", W'(rdv_cnt), W'(1));
    check("busy_rd_data", rd_data, '0);

    // Back-to-back with req_valid held
    accept("b2b", ONES);
    req_valid = 1'b1;
    wr_data = WB;
    acc2 = 0; rdv_a = 0; rdv_b = 0; en_tot = 0; acc_done = 1'b0;
    for (int idx = 1; idx <= 160; idx++) begin
      if (cfg_en) en_tot++;
      if (rd_valid) begin
        if (rdv_a == 0) rdv_a = idx;
        else if (rdv_b == 0) rdv_b = idx;
      end
      if (req_ready && !acc_done) begin
        acc2 = idx;
        acc_done = 1'b1;
      end
      step();
      if (acc_done) req_valid = 1'b0;
    end
    check("b2b_accept_at", W'(acc2), W'(69));
    check("b2b_rdv_first", W'(rdv_a), W'(68));
    check("b2b_rdv_period", W'(rdv_b - rdv_a), W'(69));
    check("b2b_en_total", W'(en_tot), W'(134));
    check("b2b_chain", chain, WB);
    check("b2b_rd_data", rd_data, ONES);

    // Asynchronous reset mid-shift
    accept("mrst", ONES);
    for (int idx = 1; idx < 30; idx++) step();
    check("mrst_pre_en", W'(cfg_en), W'(1));
    #2 rst = 1'b0;
    #1;
    check("mrst_cfg_en", W'(cfg_en), W'(0));
    check("mrst_busy", W'(busy), W'(0));
    check("mrst_cfg_i", W'(cfg_i), W'(0));
    check("mrst_rd_valid", W'(rd_valid), W'(0));
    check("mrst_rd_data", rd_data, '0);
    step();
    #4 rst = 1'b1;
    step();
    check("mrst_req_ready", W'(req_ready), W'(1));
    accept("post", W6);
    observe(0, en_cnt, en_first, en_last, seq, rdv_first, rdv_cnt, rdy_first);
    check("post_en_cnt", W'(en_cnt), W'(67));
    check("post_cfg_i_seq", seq, W6);
    check("post_chain", chain, W6);
    check("post_rdv_cnt", W'(rdv_cnt), W'(1));
    check("post_rdv_at", W'(rdv_first), W'(68));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
